// File: rtl/mem_stall_bridge.sv
// Stalls the single-cycle core on data-memory accesses and runs a req/ack handshake with watchdog and alignment check.
// Optional posted-write buffer is enabled by defining MEM_STALL_BRIDGE_WBUF_EN.
module mem_stall_bridge #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        err
);

`ifdef MEM_STALL_BRIDGE_WBUF_EN
  localparam bit WBUF_EN = 1'b1;
`else
  localparam bit WBUF_EN = 1'b0;
`endif

  // TIMEOUT=0 would give a zero-width counter; keep one bit so the logic stays legal.
  localparam int unsigned WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] TO_VAL = WDW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [31:0]      cpu_rdata_q, cpu_rdata_d;
  logic             err_q, err_d;
  logic [WDW-1:0]   wdog_q, wdog_d;
  logic             posted_q, posted_d;
  logic             access_s;
  logic             post_s;

  assign access_s = cpu_read | cpu_write;
  assign post_s   = WBUF_EN & cpu_write & ~cpu_read;

  // State and datapath registers; asynchronous reset discards any in-flight access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
      cpu_rdata_q <= 32'h0000_0000;
      err_q       <= 1'b0;
      wdog_q      <= '0;
      posted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      err_q       <= err_d;
      wdog_q      <= wdog_d;
      posted_q    <= posted_d;
    end
  end

  // Next-state, handshake and stall generation.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    err_d       = err_q;
    wdog_d      = wdog_q;
    posted_d    = posted_q;
    cpu_stall   = 1'b0;

    case (state_q)
      IDLE: begin
        cpu_stall = access_s;
        if (access_s) begin
          if (cpu_read && cpu_write) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (cpu_addr[1:0] != 2'b00) begin
            err_d       = 1'b1;
            cpu_rdata_d = ERR_DATA;
            state_d     = DONE;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = cpu_write;
            mem_addr_d  = {cpu_addr[31:2], 2'b00};
            mem_wdata_d = cpu_wdata;
            wdog_d      = '0;
            state_d     = REQ;
            // A posted write lets the core retire the store this cycle.
            if (post_s) begin
              posted_d  = 1'b1;
              cpu_stall = 1'b0;
            end else begin
              posted_d  = 1'b0;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end

      REQ: begin
        cpu_stall = posted_q ? access_s : 1'b1;
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = DONE;
          if (!mem_we_q) begin
            cpu_rdata_d = mem_rdata;
          end else begin
            cpu_rdata_d = cpu_rdata_q;
          end
        end else begin
          wdog_d = wdog_q + WDW'(1);
          if ((TIMEOUT != 0) && (wdog_d == TO_VAL)) begin
            mem_req_d = 1'b0;
            err_d     = 1'b1;
            state_d   = DONE;
            if (!posted_q) begin
              cpu_rdata_d = ERR_DATA;
            end else begin
              cpu_rdata_d = cpu_rdata_q;
            end
          end else begin
            state_d = REQ;
          end
        end
      end

      DONE: begin
        // After a posted write the waiting access has not been served yet.
        cpu_stall = posted_q & access_s;
        posted_d  = 1'b0;
        state_d   = IDLE;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        posted_d  = 1'b0;
      end
    endcase
  end

  assign cpu_rdata = cpu_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_stall_bridge.sv
// Directed self-checking bench for mem_stall_bridge (TIMEOUT overridden to 8).
module tb_mem_stall_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        err;

  int n_pass  = 0;
  int n_total = 0;

  mem_stall_bridge #(.TIMEOUT(8), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .err(err)
  );

  always #5 clk = ~clk;

  // Drives one access and plays the memory; returns in the first non-stalled cycle.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input int ack_after, input logic [31:0] rdv,
                           output int n_stall, output int n_req,
                           output logic we_seen, output logic [31:0] wd_seen);
    n_stall = 0; n_req = 0; we_seen = 1'b0; wd_seen = 32'h0;
    cpu_read = rd; cpu_write = wr; cpu_addr = a; cpu_wdata = wd;
    for (int c = 0; c < 64; c++) begin
      if (mem_req) begin
        mem_ack   = (ack_after >= 0) && (n_req == ack_after);
        mem_rdata = rdv;
        we_seen   = mem_we;
        wd_seen   = mem_wdata;
        n_req++;
      end else begin
        mem_ack = 1'b0;
      end
      #1;
      if (!cpu_stall) break;
      n_stall++;
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
  endtask

  task automatic end_access();
    @(posedge clk); #1;
    cpu_read = 1'b0; cpu_write = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req got %b exp 0", mem_req); else n_pass++;
    n_total++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we got %b exp 0", mem_we); else n_pass++;
    n_total++; if (mem_addr !== 32'h0) $display("FAIL rst_mem_addr got %h exp 0", mem_addr); else n_pass++;
    n_total++; if (mem_wdata !== 32'h0) $display("FAIL rst_mem_wdata got %h exp 0", mem_wdata); else n_pass++;
    n_total++; if (cpu_rdata !== 32'h0) $display("FAIL rst_cpu_rdata got %h exp 0", cpu_rdata); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL rst_err got %b exp 0", err); else n_pass++;
    n_total++; if (cpu_stall !== 1'b0) $display("FAIL rst_stall got %b exp 0", cpu_stall); else n_pass++;
  endtask

  task automatic test_read(input logic [31:0] a, input logic [31:0] rdv, input string tag);
    int ns, nr; logic we; logic [31:0] wd;
    do_access(1'b1, 1'b0, a, 32'h0, 0, rdv, ns, nr, we, wd);
    n_total++; if (ns !== 2) $display("FAIL %s_stall got %0d exp 2", tag, ns); else n_pass++;
    n_total++; if (nr !== 1) $display("FAIL %s_req_cycles got %0d exp 1", tag, nr); else n_pass++;
    n_total++; if (we !== 1'b0) $display("FAIL %s_mem_we got %b exp 0", tag, we); else n_pass++;
    n_total++; if (cpu_rdata !== rdv) $display("FAIL %s_rdata got %h exp %h", tag, cpu_rdata, rdv); else n_pass++;
    n_total++; if (mem_addr !== a) $display("FAIL %s_addr got %h exp %h", tag, mem_addr, a); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL %s_err got %b exp 0", tag, err); else n_pass++;
    end_access();
  endtask

  task automatic test_write();
    int ns, nr; logic we; logic [31:0] wd;
    do_access(1'b0, 1'b1, 32'h0000_0020, 32'hCAFEF00D, 4, 32'h7777_7777, ns, nr, we, wd);
`ifdef MEM_STALL_BRIDGE_WBUF_EN
    n_total++; if (ns !== 0) $display("FAIL wr_stall got %0d exp 0", ns); else n_pass++;
    repeat (8) begin
      mem_ack = mem_req;
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    cpu_write = 1'b0;
    n_total++; if (mem_we !== 1'b1) $display("FAIL wr_mem_we got %b exp 1", mem_we); else n_pass++;
`else
    n_total++; if (ns !== 6) $display("FAIL wr_stall got %0d exp 6", ns); else n_pass++;
    n_total++; if (nr !== 5) $display("FAIL wr_req_cycles got %0d exp 5", nr); else n_pass++;
    n_total++; if (we !== 1'b1) $display("FAIL wr_mem_we got %b exp 1", we); else n_pass++;
    end_access();
`endif
    n_total++; if (mem_wdata !== 32'hCAFEF00D) $display("FAIL wr_wdata got %h exp cafef00d", mem_wdata); else n_pass++;
    n_total++; if (mem_addr !== 32'h0000_0020) $display("FAIL wr_addr got %h exp 00000020", mem_addr); else n_pass++;
    n_total++; if (cpu_rdata !== 32'h1234_5678) $display("FAIL wr_rdata_kept got %h exp 12345678", cpu_rdata); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL wr_err got %b exp 0", err); else n_pass++;
  endtask

  task automatic test_timeout();
    int ns, nr; logic we; logic [31:0] wd;
    do_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, -1, 32'h0, ns, nr, we, wd);
    n_total++; if (nr !== 8) $display("FAIL to_req_cycles got %0d exp 8", nr); else n_pass++;
    n_total++; if (ns !== 9) $display("FAIL to_stall got %0d exp 9", ns); else n_pass++;
    n_total++; if (cpu_rdata !== 32'hDEADBEEF) $display("FAIL to_rdata got %h exp deadbeef", cpu_rdata); else n_pass++;
    n_total++; if (err !== 1'b1) $display("FAIL to_err got %b exp 1", err); else n_pass++;
    n_total++; if (mem_req !== 1'b0) $display("FAIL to_req_drop got %b exp 0", mem_req); else n_pass++;
    end_access();
  endtask

  task automatic test_reset_mid_req();
    cpu_read = 1'b1; cpu_addr = 32'h0000_0050;
    @(posedge clk); #1;
    n_total++; if (mem_req !== 1'b1) $display("FAIL rmid_req_up got %b exp 1", mem_req); else n_pass++;
    reset = 1'b1;
    #1;
    n_total++; if (mem_req !== 1'b0) $display("FAIL rmid_req_drop got %b exp 0", mem_req); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL rmid_err got %b exp 0", err); else n_pass++;
    n_total++; if (mem_addr !== 32'h0) $display("FAIL rmid_addr got %h exp 0", mem_addr); else n_pass++;
    cpu_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_misaligned();
    int ns, nr; logic we; logic [31:0] wd;
    do_access(1'b1, 1'b0, 32'h0000_0013, 32'h0, 0, 32'h0, ns, nr, we, wd);
    n_total++; if (ns !== 1) $display("FAIL mis_stall got %0d exp 1", ns); else n_pass++;
    n_total++; if (nr !== 0) $display("FAIL mis_req_cycles got %0d exp 0", nr); else n_pass++;
    n_total++; if (cpu_rdata !== 32'hDEADBEEF) $display("FAIL mis_rdata got %h exp deadbeef", cpu_rdata); else n_pass++;
    n_total++; if (err !== 1'b1) $display("FAIL mis_err got %b exp 1", err); else n_pass++;
    end_access();
    do_access(1'b1, 1'b0, 32'h0000_0018, 32'h0, 0, 32'h0BADF00D, ns, nr, we, wd);
    n_total++; if (cpu_rdata !== 32'h0BADF00D) $display("FAIL mis_next_rdata got %h exp 0badf00d", cpu_rdata); else n_pass++;
    n_total++; if (err !== 1'b1) $display("FAIL mis_err_sticky got %b exp 1", err); else n_pass++;
    end_access();
  endtask

  task automatic test_read_write_both();
    int ns, nr; logic we; logic [31:0] wd;
    do_access(1'b1, 1'b1, 32'h0000_001C, 32'h1111_2222, 0, 32'h3333_4444, ns, nr, we, wd);
    n_total++; if (ns !== 2) $display("FAIL both_stall got %0d exp 2", ns); else n_pass++;
    n_total++; if (we !== 1'b1) $display("FAIL both_mem_we got %b exp 1", we); else n_pass++;
    n_total++; if (wd !== 32'h1111_2222) $display("FAIL both_wdata got %h exp 11112222", wd); else n_pass++;
    n_total++; if (err !== 1'b1) $display("FAIL both_err got %b exp 1", err); else n_pass++;
    n_total++; if (cpu_rdata !== 32'h0) $display("FAIL both_rdata got %h exp 0", cpu_rdata); else n_pass++;
    end_access();
  endtask

`ifdef MEM_STALL_BRIDGE_WBUF_EN
  task automatic test_wbuf();
    int stalls = 0;
    int seg = 0;
    cpu_write = 1'b1; cpu_read = 1'b0; cpu_addr = 32'h0000_0024; cpu_wdata = 32'h55AA_55AA;
    #1;
    n_total++; if (cpu_stall !== 1'b0) $display("FAIL wb_wr_stall got %b exp 0", cpu_stall); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (mem_we !== 1'b1) $display("FAIL wb_mem_we got %b exp 1", mem_we); else n_pass++;
    cpu_write = 1'b0; cpu_read = 1'b1; cpu_addr = 32'h0000_0028;
    for (int c = 0; c < 40; c++) begin
      if (mem_req) begin
        mem_ack   = mem_we ? (seg == 3) : 1'b1;
        mem_rdata = mem_we ? 32'hFFFF_0000 : 32'h600D_CAFE;
        seg++;
      end else begin
        mem_ack = 1'b0; seg = 0;
      end
      #1;
      if (!cpu_stall) break;
      stalls++;
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    n_total++; if (stalls !== 7) $display("FAIL wb_rd_stall got %0d exp 7", stalls); else n_pass++;
    n_total++; if (cpu_rdata !== 32'h600D_CAFE) $display("FAIL wb_rd_rdata got %h exp 600dcafe", cpu_rdata); else n_pass++;
    n_total++; if (mem_addr !== 32'h0000_0028) $display("FAIL wb_rd_addr got %h exp 00000028", mem_addr); else n_pass++;
    end_access();
  endtask
`endif

  initial begin
    test_reset();
    test_read(32'h0000_0010, 32'h1234_5678, "rd1");
    test_write();
    test_timeout();
    test_reset_mid_req();
    test_read(32'h0000_0010, 32'h1234_5678, "rd_after_rst");
    test_misaligned();
    do_reset();
    test_read_write_both();
`ifdef MEM_STALL_BRIDGE_WBUF_EN
    do_reset();
    test_wbuf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
